// File: rtl/vinstr_tx_pkg.sv
// Shared opcode constants and the packed word layout for the vector instruction channel.
// Layout of vtx_word_t is also relied on by the vector decoder side.
package vinstr_tx_pkg;

  localparam logic [6:0] VOP_ARITH = 7'h57;
  localparam logic [6:0] VOP_LOAD  = 7'h07;
  localparam logic [6:0] VOP_STORE = 7'h27;
  localparam logic [2:0] VF3_CFG   = 3'b111;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] data2;
    logic [31:0] data1;
  } vtx_word_t;

  function automatic logic is_vector_op(input logic [6:0] opcode);
    return (opcode == VOP_ARITH) || (opcode == VOP_LOAD) || (opcode == VOP_STORE);
  endfunction

  function automatic logic is_vset(input logic [31:0] instr);
    return (instr[6:0] == VOP_ARITH) && (instr[14:12] == VF3_CFG);
  endfunction

endpackage

// File: rtl/vtx_fifo.sv
// First-word-fall-through FIFO with synchronous clear; DEPTH must be a power of two >= 2.
module vtx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntFull);
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign rdata_o = r_mem[r_rptr];
  assign count_o = r_count;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clr_i) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

endmodule

// File: rtl/vinstr_tx.sv
// Scalar-side transmitter: filters vector opcodes, packs {instr, rs2, rs1} and buffers them.
// Optional `VTX_VSET_SQUASH_EN suppresses a vset identical to the last one enqueued.
module vinstr_tx
  import vinstr_tx_pkg::*;
#(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned DATA_FROM_SCALAR = 96,
  parameter int unsigned DROP_CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [31:0]                 instr_i,
  input  logic [31:0]                 rs1_data_i,
  input  logic [31:0]                 rs2_data_i,
  input  logic                        flush_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_FROM_SCALAR-1:0] vector_instructions,
  output logic [$clog2(DEPTH):0]      pending_o,
  output logic [DROP_CNT_W-1:0]       dropped_o
);

  localparam logic [DROP_CNT_W-1:0] DropMax = '1;

  vtx_word_t                   w_word;
  logic [DATA_FROM_SCALAR-1:0] w_head;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_xfer;
  logic                        w_is_vec;
  logic                        w_squash;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_drop;
  logic [DROP_CNT_W-1:0]       r_dropped;

  assign w_word.instr = instr_i;
  assign w_word.data2 = rs2_data_i;
  assign w_word.data1 = rs1_data_i;

  assign ready_o  = ~w_full;
  assign w_xfer   = valid_i & ready_o;
  assign w_is_vec = is_vector_op(instr_i[6:0]);
  assign w_push   = w_xfer & w_is_vec & ~w_squash & ~flush_i;
  // A flush cycle discards whatever is offered and leaves the drop count alone.
  assign w_drop   = w_xfer & ~w_is_vec & ~flush_i;

  assign valid_o             = ~w_empty;
  assign w_pop               = valid_o & ready_i;
  assign vector_instructions = valid_o ? w_head : '0;
  assign dropped_o           = r_dropped;

`ifdef VTX_VSET_SQUASH_EN
  logic [63:0] r_last_vset;
  logic        r_last_valid;
  logic        w_vset;

  assign w_vset   = is_vset(instr_i);
  assign w_squash = w_xfer & w_vset & r_last_valid & ({instr_i, rs1_data_i} == r_last_vset);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_vset  <= '0;
      r_last_valid <= 1'b0;
    end else if (flush_i) begin
      r_last_valid <= 1'b0;
    end else if (w_xfer && w_vset && !w_squash) begin
      r_last_vset  <= {instr_i, rs1_data_i};
      r_last_valid <= 1'b1;
    end
  end
`else
  assign w_squash = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropped <= '0;
    end else if (w_drop && (r_dropped != DropMax)) begin
      r_dropped <= r_dropped + 1'b1;
    end
  end

  vtx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_FROM_SCALAR)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_word),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (pending_o)
  );

endmodule

// File: tb/tb_vinstr_tx.sv
// Scoreboard bench for vinstr_tx: a queue-based reference model fed from the input side,
// checked by an output monitor every cycle.
module tb_vinstr_tx;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [95:0] vector_instructions;
  logic [2:0]  pending_o;
  logic [15:0] dropped_o;

  vinstr_tx #(
    .DEPTH            (DEPTH),
    .DATA_FROM_SCALAR (96),
    .DROP_CNT_W       (16)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .instr_i             (instr_i),
    .rs1_data_i          (rs1_data_i),
    .rs2_data_i          (rs2_data_i),
    .flush_i             (flush_i),
    .valid_o             (valid_o),
    .ready_i             (ready_i),
    .vector_instructions (vector_instructions),
    .pending_o           (pending_o),
    .dropped_o           (dropped_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  logic [95:0] exp_q[$];
  int unsigned m_drop = 0;
  bit          m_ready = 1'b1;
  bit          m_last_v = 1'b0;
  logic [63:0] m_last = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: status checks against the model, then compare and retire the head on a pop.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    if (rst_n) begin
      chk("valid_o", 96'(valid_o), 96'(sz != 0));
      chk("ready_o", 96'(ready_o), 96'(sz != DEPTH));
      chk("pending_o", 96'(pending_o), 96'(sz));
      chk("dropped_o", 96'(dropped_o), 96'(m_drop));
      if (sz != 0) chk("head word", vector_instructions, exp_q[0]);
      else         chk("idle word", vector_instructions, 96'(0));
      m_ready = (sz != DEPTH);
      if (sz != 0 && ready_i) begin
        void'(exp_q.pop_front());
        n_out++;
      end
    end
  end

  // Input-side model: what the scalar side offered this cycle and what must follow from it.
  always begin
    bit squash;
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (flush_i) begin
        exp_q.delete();
        m_last_v = 1'b0;
      end else if (valid_i && m_ready) begin
        if (instr_i[6:0] inside {7'h57, 7'h07, 7'h27}) begin
          squash = 1'b0;
`ifdef VTX_VSET_SQUASH_EN
          if (instr_i[6:0] == 7'h57 && instr_i[14:12] == 3'b111) begin
            squash = m_last_v && (m_last == {instr_i, rs1_data_i});
            if (!squash) begin
              m_last   = {instr_i, rs1_data_i};
              m_last_v = 1'b1;
            end
          end
`endif
          if (!squash) exp_q.push_back({instr_i, rs2_data_i, rs1_data_i});
        end else if (m_drop != 32'hFFFF) begin
          m_drop++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit ok;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 64);
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept timeout: ready_o stayed 0, expected a transfer within 64 cycles");
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    valid_i    = 1'b1;
    instr_i    = ins;
    rs1_data_i = r1;
    rs2_data_i = r2;
    wait_accept();
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  function automatic logic [31:0] rnd_vec(input int i);
    logic [6:0] ops [3];
    ops = '{7'h57, 7'h07, 7'h27};
    return {$urandom[31:7], ops[i % 3]};
  endfunction

  initial begin
    int base;
    #2;
    chk("reset valid_o", 96'(valid_o), 96'(0));
    chk("reset ready_o", 96'(ready_o), 96'(1));
    chk("reset pending_o", 96'(pending_o), 96'(0));
    chk("reset dropped_o", 96'(dropped_o), 96'(0));
    chk("reset word", vector_instructions, 96'(0));
    cyc(2);
    rst_n = 1'b1;

    // Single vadd straight through
    ready_i = 1'b1;
    send(32'h0000_0057, 32'h11, 32'h22);
    idle();
    @(negedge clk);
    chk("t1 word", vector_instructions, 96'h00000057_00000022_00000011);
    cyc(3);

    // Backpressure: four fill the FIFO, the fifth waits for space
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd_vec(i), $urandom, $urandom);
    valid_i = 1'b1;
    instr_i = rnd_vec(4);
    cyc(2);
    chk("t2 full pending", 96'(pending_o), 96'(4));
    chk("t2 full ready", 96'(ready_o), 96'(0));
    ready_i = 1'b1;
    wait_accept();
    idle();
    cyc(8);

    // Non-vector drop and counter saturation
    send(32'h0000_0013, 32'h1, 32'h2);
    idle();
    cyc(2);
    chk("t3 one drop", 96'(dropped_o), 96'(1));
    valid_i = 1'b1;
    instr_i = 32'h0000_0013;
    cyc(65536);
    idle();
    cyc(2);
    chk("t3 saturated", 96'(dropped_o), 96'(16'hFFFF));

    // Flush with a pop and a push in the same cycle
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_vec(i), $urandom, $urandom);
    base    = n_out;
    valid_i = 1'b1;
    instr_i = rnd_vec(1);
    flush_i = 1'b1;
    ready_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    idle();
    @(negedge clk);
    chk("t4 pending after flush", 96'(pending_o), 96'(0));
    chk("t4 valid after flush", 96'(valid_o), 96'(0));
    chk("t4 head popped", 96'(n_out - base), 96'(1));
    cyc(2);

    // Full FIFO: pop and offer in the same cycle, no push
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(rnd_vec(i), $urandom, $urandom);
    valid_i = 1'b1;
    instr_i = rnd_vec(2);
    ready_i = 1'b1;
    cyc(1);
    idle();
    ready_i = 1'b0;
    @(negedge clk);
    chk("t5 pending", 96'(pending_o), 96'(3));
    ready_i = 1'b1;
    cyc(6);

`ifdef VTX_VSET_SQUASH_EN
    // Repeated vsetvli squashing
    base = n_out;
    send(32'h0C00_72D7, 32'd16, 32'd0);
    send(32'h0C00_72D7, 32'd16, 32'd0);
    send(32'h0C00_72D7, 32'd8, 32'd0);
    idle();
    cyc(4);
    chk("t6 emitted", 96'(n_out - base), 96'(2));
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    send(32'h0C00_72D7, 32'd8, 32'd0);
    idle();
    cyc(3);
    chk("t6 after flush", 96'(n_out - base), 96'(3));
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel        = int'($urandom_range(0, 5));
      valid_i    = ($urandom_range(0, 2) != 0);
      ready_i    = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 19) == 0);
      rs1_data_i = $urandom_range(0, 1);
      rs2_data_i = $urandom;
      if (sel == 0) instr_i = 32'h0C00_72D7;
      else if (sel == 1 && !flush_i) instr_i = {$urandom[31:7], 7'h13};
      else instr_i = rnd_vec(sel);
      cyc(1);
    end
    flush_i = 1'b0;
    idle();
    ready_i = 1'b1;
    cyc(8);

    // Asynchronous reset with words buffered
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_vec(i), $urandom, $urandom);
    idle();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_drop   = 0;
    m_last_v = 1'b0;
    m_ready  = 1'b1;
    #1;
    chk("async rst valid_o", 96'(valid_o), 96'(0));
    chk("async rst pending_o", 96'(pending_o), 96'(0));
    chk("async rst dropped_o", 96'(dropped_o), 96'(0));
    chk("async rst ready_o", 96'(ready_o), 96'(1));
    cyc(1);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    send(32'h0000_0027, 32'hAAAA, 32'h5555);
    idle();
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
